// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier: 16x16 -> 32, one add/sub/shift per clock.
// A single 16-bit carry-lookahead adder is time-shared across all iterations.

module booth_cla16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] carry;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  cg;
    logic        c;

    // Two-level lookahead: 4-bit groups, group carries resolved in parallel.
    always_comb begin
        p     = x ^ y;
        g     = x & y;
        carry = '0;
        gg    = '0;
        gp    = '0;
        cg    = '0;
        c     = 1'b0;

        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end

        cg[0] = cin;
        cg[1] = gg[0] | (gp[0] & cin);
        cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

        for (int k = 0; k < 4; k++) begin
            c = cg[k];
            for (int i = 0; i < 4; i++) begin
                carry[4*k+i] = c;
                c = g[4*k+i] | (p[4*k+i] & c);
            end
        end

        sum = p ^ carry;
    end

endmodule

module booth_seq_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned ACC_W = WIDTH + 1;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;

    logic               do_add;
    logic               do_sub;
    logic [WIDTH-1:0]   y;
    logic               cin;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [ACC_W-1:0]   acc_op;
    logic [ACC_W-1:0]   acc_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic               q_m1_nxt;

    booth_cla16 u_cla (
        .x    (acc[WIDTH-1:0]),
        .y    (y),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // Booth decode, 17-bit add/sub (sign-extended carry into bit 16), then arithmetic shift.
    always_comb begin
        do_add   = ({q[0], q_m1} == 2'b01);
        do_sub   = ({q[0], q_m1} == 2'b10);
        y        = do_sub ? ~m : m;
        cin      = do_sub;
        acc_op   = acc;
        if (do_add || do_sub) begin
            acc_op = {acc[WIDTH] ^ y[WIDTH-1] ^ cout, sum};
        end
        acc_nxt  = {acc_op[WIDTH], acc_op[WIDTH:1]};
        q_nxt    = {acc_op[0], q[WIDTH-1:1]};
        q_m1_nxt = q[0];
    end

    // A start seen in DONE is taken directly so results can issue every 17 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            m       <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    q    <= q_nxt;
                    q_m1 <= q_m1_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        product <= {acc_nxt[WIDTH-1:0], q_nxt};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and random checks of booth_seq_mult: latency, handshake, reset and product values.

module tb_booth_seq_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_checks;
    int n_fail;

    booth_seq_mult #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single multiply from IDLE; inputs scrambled after the accepting edge.
    task automatic mult_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] exp);
        int cyc;
        int bcnt;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        tick();
        start        = 1'b0;
        multiplicand = 16'hA5A5;
        multiplier   = 16'h5A5A;
        bcnt = busy ? 1 : 0;
        cyc  = 0;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
            if (busy) bcnt++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd16);
        check({tag, " busy_cycles"}, 32'(bcnt), 32'd16);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " product"}, product, exp);
        tick();
        check({tag, " done_after"}, 32'(done), 32'd0);
        check({tag, " product_hold"}, product, exp);
    endtask

    // Start held high: one accept every 17 edges, product checked at each done.
    task automatic b2b(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp);
        multiplicand = a;
        multiplier   = b;
        tick();
        check({tag, " accept_busy"}, {30'd0, busy, done}, 32'd2);
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        repeat (16) tick();
        check({tag, " done_product"}, {31'd0, done}, 32'd1);
        check({tag, " product"}, product, exp);
    endtask

    initial begin
        int saw_done;
        int bcnt;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] rexp;
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", product, 32'd0);
        rst = 1'b0;
        tick();

        mult_check("3x5", 16'd3, 16'd5, 32'h0000000F);
        mult_check("-7x6", 16'hFFF9, 16'd6, 32'hFFFFFFD6);
        mult_check("0x-1", 16'd0, 16'hFFFF, 32'h00000000);
        mult_check("min x min", 16'h8000, 16'h8000, 32'h40000000);
        mult_check("max x min", 16'h7FFF, 16'h8000, 32'hC0008000);

        // Second start during RUN must be ignored.
        start = 1'b1; multiplicand = 16'd2; multiplier = 16'd3;
        tick();
        start = 1'b0; multiplicand = 16'd9; multiplier = 16'd9;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 20 && saw_done == 0; i++) begin
            tick();
            if (done) saw_done = 6 + i;
        end
        check("ignore latency", 32'(saw_done), 32'd16);
        check("ignore product", product, 32'h00000006);
        bcnt = 0;
        repeat (20) begin
            tick();
            if (busy) bcnt++;
        end
        check("ignore no_second_busy", 32'(bcnt), 32'd0);

        // Reset in the middle of RUN.
        start = 1'b1; multiplicand = 16'd100; multiplier = 16'd200;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst product", product, 32'd0);
        rst = 1'b0;
        saw_done = 0;
        repeat (20) begin
            tick();
            if (done) saw_done++;
        end
        check("midrst no_done", 32'(saw_done), 32'd0);
        mult_check("after rst", 16'd100, 16'd200, 32'h00004E20);

        // Reset and start on the same edge: request dropped.
        rst = 1'b1; start = 1'b1; multiplicand = 16'd7; multiplier = 16'd7;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", 32'(busy), 32'd0);
        tick();
        check("rst+start idle", 32'(busy), 32'd0);

        // Back-to-back with alternating operands.
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) b2b($sformatf("b2b%0d", k), 16'd1234, 16'hE9D2, 32'hFF951644);
            else            b2b($sformatf("b2b%0d", k), 16'hFFFF, 16'hFFFF, 32'h00000001);
        end

        // Random vectors against a behavioural signed multiply.
        for (int k = 0; k < 2000; k++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rexp = 32'($signed(ra) * $signed(rb));
            b2b($sformatf("rnd%0d", k), ra, rb, rexp);
        end
        start = 1'b0;
        tick();
        check("final done", 32'(done), 32'd0);
        check("final busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
